block_fifo_gen2: RTL
====================

BLOCK_FIFO_GEN2 -- requirements
Module: block_fifo_gen2

Interface
REQ-001 Parameter WIDTH, default 9, data word width in bits (1..64).
REQ-002 Parameter DEPTH, default 16, word capacity; SHALL be a power of two, 4..4096.
REQ-003 Parameter FWFT, default 0, 0 = standard read mode, 1 = first-word-fall-through mode.
REQ-004 Derived CW = log2(DEPTH)+1, count width; it SHALL represent 0..DEPTH inclusive.
REQ-005 Clk  in  1  single clock; all logic on rising edge.
REQ-006 Reset_n  in  1  synchronous, active-low reset.
REQ-007 Din  in  WIDTH  write data; Write  in  1  write request.
REQ-008 Read  in  1  read request (standard) / pop acknowledge (FWFT).
REQ-009 ProgFullThresh  in  CW  runtime prog-full level; ProgEmptyThresh  in  CW  runtime prog-empty level.
REQ-010 ClearErr  in  1  clears sticky error flags.
REQ-011 Dout  out  WIDTH  read data; Valid  out  1  Dout qualifier.
REQ-012 Full, AlmostFull, Empty, ProgFull, ProgEmpty  out  1 each  status flags.
REQ-013 DataCount  out  CW  occupancy; Overflow, Underflow  out  1 each  sticky error flags.

Function
REQ-014 Storage SHALL be inferred block RAM with registered read port; pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0.
REQ-015 Accepted write: Write=1 and Full=0; stores Din, increments write pointer.
REQ-016 Write with Full=1 SHALL be dropped, even with Read in the same cycle, and SHALL set Overflow next cycle.
REQ-017 Standard mode: accepted read = Read=1 and Empty=0; Dout/Valid update next cycle, Valid high exactly one cycle per accepted read; Dout holds last value otherwise.
REQ-018 Standard mode: Read with Empty=1 SHALL be dropped and set Underflow, including when Write is high the same cycle (write still accepted).
REQ-019 FWFT mode: head word SHALL appear on Dout with Valid=1 without Read; Read with Valid=1 pops it, next word (if any) presented next cycle with Valid held high.
REQ-020 FWFT mode: Empty = NOT Valid; Read with Valid=0 SHALL be dropped and set Underflow.
REQ-021 FWFT latency: write to an empty FIFO in cycle N gives Valid=1, Dout=that word in cycle N+2.
REQ-022 DataCount = words accepted minus words popped (includes the FWFT output word); updates the cycle after the event; simultaneous accepted read and write leave it unchanged.
REQ-023 Standard mode Empty = (DataCount==0); Full = (DataCount==DEPTH); AlmostFull = (DataCount>=DEPTH-1).
REQ-024 ProgFull = (DataCount>=ProgFullThresh); ProgEmpty = (DataCount<=ProgEmptyThresh); thresholds compared every cycle, change takes effect next cycle.
REQ-025 All flags SHALL be registered (no combinational path from any input to any output).
REQ-026 ClearErr=1 clears Overflow/Underflow next cycle; a new error in the same cycle SHALL win (flag set).

Reset
REQ-027 Reset_n=0 at a rising edge SHALL zero pointers and DataCount, and set Dout=0, Valid=0, Full=0, AlmostFull=0, Overflow=0, Underflow=0, Empty=1, ProgFull=(ProgFullThresh==0), ProgEmpty=1.
REQ-028 Reset SHALL override Read/Write/ClearErr in the same cycle; stored data is discarded, including mid-operation and when full.
REQ-029 RAM contents need not be cleared by reset.

Verification
REQ-030 FWFT=0, DEPTH=16: write 0x000..0x00F -> Full=1, AlmostFull=1, DataCount=16; 17th write -> Overflow=1, count stays 16; 16 reads -> Dout 0x000..0x00F in order, one cycle after each Read, Empty=1 at end.
REQ-031 FWFT=1: single write 0x1A5 at cycle N into empty FIFO -> Valid=1, Dout=0x1A5, Empty=0 at N+2 with Read=0; Read at N+2 -> Valid=0, Empty=1 at N+3.
REQ-032 Both modes: fill 8 words, then 40 cycles of Read=Write=1 -> DataCount stays 8, pointers wrap, output sequence equals input sequence.
REQ-033 ProgFullThresh=10, ProgEmptyThresh=3: count 3 -> ProgEmpty=1; count 4 -> 0; count 10 -> ProgFull=1; change ProgFullThresh to 12 -> ProgFull=0 next cycle.
REQ-034 Empty FIFO, Read=Write=1 -> Underflow=1, DataCount=1; ClearErr with a simultaneous Read on empty -> Underflow stays 1.
REQ-035 Reset_n=0 with FIFO full and Write=1 -> next cycle DataCount=0, Empty=1, Full=0, Valid=0, Overflow=0.

Source files
------------

// File: rtl/block_fifo_gen2.sv
// Synchronous FIFO on inferred block RAM with registered status flags,
// runtime programmable thresholds, sticky error flags and optional FWFT output.
module block_fifo_gen2 #(
   parameter int  WIDTH = 9,
   parameter int  DEPTH = 16,
   parameter int  FWFT  = 0,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_write,
   input  logic             i_read,
   input  logic [CW-1:0]    i_prog_full_thresh,
   input  logic [CW-1:0]    i_prog_empty_thresh,
   input  logic             i_clear_err,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_valid,
   output logic             o_full,
   output logic             o_almost_full,
   output logic             o_empty,
   output logic             o_prog_full,
   output logic             o_prog_empty,
   output logic [CW-1:0]    o_data_count,
   output logic             o_overflow,
   output logic             o_underflow
);

   localparam logic [CW-1:0] LP_FULL  = CW'(DEPTH);
   localparam logic [CW-1:0] LP_AFULL = CW'(DEPTH - 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_dout;
   logic             r_valid;
   logic             r_full;
   logic             r_almost_full;
   logic             r_empty;
   logic             r_prog_full;
   logic             r_prog_empty;
   logic             r_overflow;
   logic             r_underflow;

   logic             w_wr_acc;
   logic             w_pop;
   logic             w_fetch;
   logic             w_valid_next;
   logic             w_empty_next;
   logic             w_overflow_evt;
   logic             w_underflow_evt;
   logic [CW-1:0]    w_count_next;

   assign w_wr_acc       = i_write & ~r_full;
   assign w_overflow_evt = i_write & r_full;
   assign w_count_next   = r_count + CW'(w_wr_acc) - CW'(w_pop);

   // w_fetch moves a word from RAM into the output register; w_pop removes it
   // from the FIFO's occupancy. In standard mode they are the same event.
   generate
      if (FWFT == 0) begin : g_std
         assign w_pop           = i_read & ~r_empty;
         assign w_fetch         = w_pop;
         assign w_valid_next    = w_pop;
         assign w_empty_next    = (w_count_next == '0);
         assign w_underflow_evt = i_read & r_empty;
      end else begin : g_fwft
         logic [CW-1:0] r_ram_cnt;

         assign w_pop           = i_read & r_valid;
         assign w_fetch         = (r_ram_cnt != '0) & (~r_valid | w_pop);
         assign w_valid_next    = w_fetch | (r_valid & ~w_pop);
         assign w_empty_next    = ~w_valid_next;
         assign w_underflow_evt = i_read & ~r_valid;

         always_ff @(posedge i_clk) begin
            if (!i_reset_n) begin
               r_ram_cnt <= '0;
            end else begin
               r_ram_cnt <= r_ram_cnt + CW'(w_wr_acc) - CW'(w_fetch);
            end
         end
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (w_wr_acc && i_reset_n) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_dout <= '0;
      end else if (w_fetch) begin
         r_dout <= r_mem[r_rd_ptr];
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_valid       <= 1'b0;
         r_full        <= 1'b0;
         r_almost_full <= 1'b0;
         r_empty       <= 1'b1;
         r_prog_full   <= (i_prog_full_thresh == '0);
         r_prog_empty  <= 1'b1;
         r_overflow    <= 1'b0;
         r_underflow   <= 1'b0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_fetch)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count       <= w_count_next;
         r_valid       <= w_valid_next;
         r_full        <= (w_count_next == LP_FULL);
         r_almost_full <= (w_count_next >= LP_AFULL);
         r_empty       <= w_empty_next;
         r_prog_full   <= (w_count_next >= i_prog_full_thresh);
         r_prog_empty  <= (w_count_next <= i_prog_empty_thresh);
         // A fresh error in the clearing cycle keeps the flag set.
         r_overflow    <= w_overflow_evt | (r_overflow & ~i_clear_err);
         r_underflow   <= w_underflow_evt | (r_underflow & ~i_clear_err);
      end
   end

   assign o_dout        = r_dout;
   assign o_valid       = r_valid;
   assign o_full        = r_full;
   assign o_almost_full = r_almost_full;
   assign o_empty       = r_empty;
   assign o_prog_full   = r_prog_full;
   assign o_prog_empty  = r_prog_empty;
   assign o_data_count  = r_count;
   assign o_overflow    = r_overflow;
   assign o_underflow   = r_underflow;

endmodule
